// File: rtl/label_arbiter_if.sv
// Requester-side and label-store-side signals of label_arbiter.
// The arbiter uses the slave view; requesters and the store model use the master view.
interface label_arbiter_if #(
   parameter int N_REQ   = 3,
   parameter int ID_W    = 13,
   parameter int LABEL_W = 128
) ();
   logic [N_REQ-1:0]         req_valid;
   logic [N_REQ-1:0]         req_wr;
   logic [ID_W*N_REQ-1:0]    req_id;
   logic [LABEL_W*N_REQ-1:0] req_label;
   logic [N_REQ-1:0]         req_ready;
   logic [N_REQ-1:0]         rsp_valid;
   logic [LABEL_W-1:0]       rsp_label;
   logic                     rsp_err;

   logic [ID_W-1:0]          la_wire_id;
   logic                     la_id_strobe;
   logic                     la_wr_en;
   logic [LABEL_W-1:0]       la_label_in;
   logic [LABEL_W-1:0]       la_label_out;
   logic                     la_done;

   modport slave (
      input  req_valid, req_wr, req_id, req_label, la_label_out, la_done,
      output req_ready, rsp_valid, rsp_label, rsp_err,
             la_wire_id, la_id_strobe, la_wr_en, la_label_in
   );

   modport master (
      output req_valid, req_wr, req_id, req_label, la_label_out, la_done,
      input  req_ready, rsp_valid, rsp_label, rsp_err,
             la_wire_id, la_id_strobe, la_wr_en, la_label_in
   );
endinterface

// File: rtl/label_arbiter.sv
// Round-robin arbiter sharing one 128-bit label store among N_REQ requesters,
// holding store inputs for the whole transaction and aborting hung transactions.
module label_arbiter #(
   parameter int N_REQ   = 3,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   label_arbiter_if.slave   bus,
   output logic             err_timeout,
   output logic             busy
);
   localparam int ID_W    = 13;
   localparam int LABEL_W = 128;
   localparam int GW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [GW-1:0] LAST_INIT = GW'(N_REQ - 1);
   localparam logic [7:0]    TO_VAL    = 8'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t               state, state_nxt;
   logic [GW-1:0]        last_grant, last_grant_nxt;
   logic [GW-1:0]        pick_g;
   logic [7:0]           wd_cnt, wd_cnt_nxt;

   logic [ID_W-1:0]      wire_id_q, wire_id_nxt;
   logic                 wr_en_q, wr_en_nxt;
   logic [LABEL_W-1:0]   label_in_q, label_in_nxt;
   logic                 strobe_q, strobe_nxt;
   logic [N_REQ-1:0]     ready_q, ready_nxt;
   logic [N_REQ-1:0]     rsp_valid_q, rsp_valid_nxt;
   logic [LABEL_W-1:0]   rsp_label_q, rsp_label_nxt;
   logic                 rsp_err_q, rsp_err_nxt;
   logic                 err_to_q, err_to_nxt;
   logic                 busy_q, busy_nxt;

   // First requesting index strictly after 'last', wrapping around; the
   // downward scan lets the nearest candidate overwrite farther ones.
   function automatic logic [GW-1:0] pick_grant(input logic [N_REQ-1:0] vld,
                                                input logic [GW-1:0]    last);
      logic [GW-1:0] g;
      int            idx;
      g = last;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = int'(last) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (vld[idx]) g = idx[GW-1:0];
      end
      return g;
   endfunction

   assign pick_g = pick_grant(bus.req_valid, last_grant);

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      wd_cnt_nxt     = wd_cnt;
      wire_id_nxt    = wire_id_q;
      wr_en_nxt      = wr_en_q;
      label_in_nxt   = label_in_q;
      strobe_nxt     = 1'b0;
      ready_nxt      = '0;
      rsp_valid_nxt  = '0;
      rsp_err_nxt    = 1'b0;
      rsp_label_nxt  = rsp_label_q;
      err_to_nxt     = err_to_q;
      busy_nxt       = busy_q;

      case (state)
         IDLE: begin
            if (|bus.req_valid) begin
               last_grant_nxt    = pick_g;
               wire_id_nxt       = bus.req_id[ID_W*pick_g +: ID_W];
               wr_en_nxt         = bus.req_wr[pick_g];
               label_in_nxt      = bus.req_label[LABEL_W*pick_g +: LABEL_W];
               strobe_nxt        = 1'b1;
               ready_nxt[pick_g] = 1'b1;
               wd_cnt_nxt        = '0;
               busy_nxt          = 1'b1;
               state_nxt         = WAIT;
            end
         end
         WAIT: begin
            wd_cnt_nxt = wd_cnt + 8'd1;
            // A done arriving on the timeout cycle still counts as success.
            if (bus.la_done) begin
               if (!wr_en_q) rsp_label_nxt = bus.la_label_out;
               rsp_valid_nxt[last_grant] = 1'b1;
               state_nxt = RESP;
            end else if (wd_cnt + 8'd1 == TO_VAL) begin
               rsp_valid_nxt[last_grant] = 1'b1;
               rsp_err_nxt = 1'b1;
               err_to_nxt  = 1'b1;
               state_nxt   = RESP;
            end
         end
         RESP: begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end
         default: begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         last_grant  <= LAST_INIT;
         wd_cnt      <= '0;
         wire_id_q   <= '0;
         wr_en_q     <= 1'b0;
         label_in_q  <= '0;
         strobe_q    <= 1'b0;
         ready_q     <= '0;
         rsp_valid_q <= '0;
         rsp_label_q <= '0;
         rsp_err_q   <= 1'b0;
         err_to_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state       <= state_nxt;
         last_grant  <= last_grant_nxt;
         wd_cnt      <= wd_cnt_nxt;
         wire_id_q   <= wire_id_nxt;
         wr_en_q     <= wr_en_nxt;
         label_in_q  <= label_in_nxt;
         strobe_q    <= strobe_nxt;
         ready_q     <= ready_nxt;
         rsp_valid_q <= rsp_valid_nxt;
         rsp_label_q <= rsp_label_nxt;
         rsp_err_q   <= rsp_err_nxt;
         err_to_q    <= err_to_nxt;
         busy_q      <= busy_nxt;
      end
   end

   assign bus.la_wire_id   = wire_id_q;
   assign bus.la_wr_en     = wr_en_q;
   assign bus.la_label_in  = label_in_q;
   assign bus.la_id_strobe = strobe_q;
   assign bus.req_ready    = ready_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_label    = rsp_label_q;
   assign bus.rsp_err      = rsp_err_q;
   assign err_timeout      = err_to_q;
   assign busy             = busy_q;
endmodule

// File: tb/tb_label_arbiter.sv
// Directed bench for label_arbiter with a behavioural label store
// (strobe-started, upper half sampled one cycle late, done 4 cycles after strobe).
module tb_label_arbiter;
   localparam int N_REQ   = 3;
   localparam int TIMEOUT = 15;
   localparam logic [127:0] RD = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] WL = {64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555};

   logic clk = 1'b0;
   logic rst;
   logic err_timeout, busy;

   label_arbiter_if #(.N_REQ(N_REQ)) bus ();

   label_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .err_timeout(err_timeout),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Behavioural store
   logic [127:0] mem [0:8191];
   logic         suppress;
   int           st;
   logic [12:0]  s_id;
   logic         s_wr;
   logic [63:0]  s_lo, s_hi;

   always @(posedge clk) begin
      if (rst) begin
         st               <= 0;
         bus.la_done      <= 1'b0;
         bus.la_label_out <= '0;
      end else begin
         bus.la_done <= 1'b0;
         case (st)
            0: if (bus.la_id_strobe) begin
               s_id <= bus.la_wire_id;
               s_wr <= bus.la_wr_en;
               s_lo <= bus.la_label_in[63:0];
               st   <= 1;
            end
            1: begin
               s_hi <= bus.la_label_in[127:64];
               st   <= 2;
            end
            2: st <= 3;
            default: begin
               st <= 0;
               if (!suppress) begin
                  bus.la_done <= 1'b1;
                  if (s_wr) mem[s_id] <= {s_hi, s_lo};
                  else      bus.la_label_out <= mem[s_id];
               end
            end
         endcase
      end
   end

   task automatic set_req(input int r, input bit wr, input logic [12:0] id, input logic [127:0] lab);
      bus.req_wr[r]             = wr;
      bus.req_id[13*r +: 13]    = id;
      bus.req_label[128*r +: 128] = lab;
   endtask

   task automatic wait_accept(input logic [2:0] exp, input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.req_ready == 0 && n < 40);
      check(tag, bus.req_ready, exp);
   endtask

   task automatic wait_rsp(input logic [2:0] exp, input string tag, output int lat);
      lat = 0;
      while (bus.rsp_valid == 0 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check(tag, bus.rsp_valid, exp);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ready"},  bus.req_ready,    0);
      check({tag, "_rspv"},   bus.rsp_valid,    0);
      check({tag, "_rspl"},   bus.rsp_label,    0);
      check({tag, "_rspe"},   bus.rsp_err,      0);
      check({tag, "_errto"},  err_timeout,      0);
      check({tag, "_id"},     bus.la_wire_id,   0);
      check({tag, "_strobe"}, bus.la_id_strobe, 0);
      check({tag, "_wr"},     bus.la_wr_en,     0);
      check({tag, "_lin"},    bus.la_label_in,  0);
      check({tag, "_busy"},   busy,             0);
   endtask

   initial begin
      int lat, seen, grants, rsps, cyc, last_t;
      int order [6];
      order = '{0, 1, 2, 0, 1, 2};
      rst = 1'b1;
      suppress = 1'b0;
      bus.req_valid = '0;
      bus.req_wr    = '0;
      bus.req_id    = '0;
      bus.req_label = '0;
      mem[13'h0005] = RD;
      repeat (3) @(negedge clk);
      check_zero("rst");
      rst = 1'b0;
      @(negedge clk);

      // Single read by requester 1
      set_req(1, 1'b0, 13'h0005, '0);
      bus.req_valid = 3'b010;
      wait_accept(3'b010, "t1_ready");
      check("t1_strobe", bus.la_id_strobe, 1);
      check("t1_id", bus.la_wire_id, 13'h0005);
      check("t1_wr", bus.la_wr_en, 0);
      check("t1_busy", busy, 1);
      bus.req_valid = '0;
      wait_rsp(3'b010, "t1_rsp", lat);
      check("t1_lat", lat, 5);
      check("t1_label", bus.rsp_label, RD);
      check("t1_err", bus.rsp_err, 0);
      @(negedge clk);
      check("t1_rsp_clr", bus.rsp_valid, 0);
      check("t1_idle", busy, 0);

      // Write by requester 0, then read back by requester 2
      set_req(0, 1'b1, 13'h1FFF, WL);
      bus.req_valid = 3'b001;
      wait_accept(3'b001, "t2_ready");
      check("t2_id", bus.la_wire_id, 13'h1FFF);
      check("t2_wr", bus.la_wr_en, 1);
      bus.req_valid = '0;
      set_req(0, 1'b0, 13'h0000, '1);
      for (int k = 1; k <= 5; k++) begin
         check("t2_hold", bus.la_label_in, WL);
         @(negedge clk);
      end
      check("t2_wrsp", bus.rsp_valid, 3'b001);
      check("t2_wlabel", bus.rsp_label, RD);
      @(negedge clk);
      set_req(2, 1'b0, 13'h1FFF, '0);
      bus.req_valid = 3'b100;
      wait_accept(3'b100, "t2_rready");
      bus.req_valid = '0;
      wait_rsp(3'b100, "t2_rrsp", lat);
      check("t2_rlabel", bus.rsp_label, WL);
      @(negedge clk);

      // Contention: all three held for six transactions
      for (int r = 0; r < 3; r++) set_req(r, 1'b0, 13'h0005, '0);
      bus.req_valid = 3'b111;
      grants = 0; rsps = 0; cyc = 0; last_t = 0;
      while (rsps < 6 && cyc < 80) begin
         @(negedge clk);
         cyc++;
         if (bus.la_id_strobe) begin
            check("t3_grant", bus.req_ready, 128'(3'b001) << order[grants % 6]);
            if (grants > 0) check("t3_gap", cyc - last_t, 7);
            last_t = cyc;
            grants++;
            if (grants == 6) bus.req_valid = '0;
         end
         if (bus.rsp_valid != 0) begin
            check("t3_rsp", bus.rsp_valid, 128'(3'b001) << order[rsps % 6]);
            rsps++;
         end
      end
      check("t3_count", rsps, 6);
      @(negedge clk);

      // Withdrawal: requester 1 pulses valid while busy and is never granted
      set_req(0, 1'b0, 13'h0005, '0);
      bus.req_valid = 3'b001;
      wait_accept(3'b001, "t4_first");
      bus.req_valid = 3'b010;
      @(negedge clk);
      bus.req_valid = 3'b100;
      wait_accept(3'b100, "t4_next");
      bus.req_valid = '0;
      wait_rsp(3'b100, "t4_rsp", lat);
      @(negedge clk);

      // Timeout: store never completes
      check("t5_errto_pre", err_timeout, 0);
      suppress = 1'b1;
      set_req(1, 1'b0, 13'h1FFF, '0);
      bus.req_valid = 3'b010;
      wait_accept(3'b010, "t5_ready");
      bus.req_valid = '0;
      for (int k = 1; k <= TIMEOUT; k++) begin
         @(negedge clk);
         if (k == 5 || k == TIMEOUT - 1) check("t5_early", bus.rsp_valid, 0);
      end
      check("t5_rsp", bus.rsp_valid, 3'b010);
      check("t5_err", bus.rsp_err, 1);
      check("t5_errto", err_timeout, 1);
      check("t5_label", bus.rsp_label, RD);
      @(negedge clk);
      check("t5_rsp_clr", bus.rsp_valid, 0);
      check("t5_err_clr", bus.rsp_err, 0);
      check("t5_sticky", err_timeout, 1);
      suppress = 1'b0;
      set_req(0, 1'b0, 13'h1FFF, '0);
      bus.req_valid = 3'b001;
      wait_accept(3'b001, "t5_next_ready");
      bus.req_valid = '0;
      wait_rsp(3'b001, "t5_next_rsp", lat);
      check("t5_next_lat", lat, 5);
      check("t5_next_err", bus.rsp_err, 0);
      check("t5_next_label", bus.rsp_label, WL);
      check("t5_next_sticky", err_timeout, 1);
      @(negedge clk);

      // Reset during WAIT
      set_req(0, 1'b0, 13'h0005, '0);
      bus.req_valid = 3'b001;
      wait_accept(3'b001, "t6_ready");
      bus.req_valid = '0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_zero("t6");
      rst = 1'b0;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.rsp_valid != 0) seen++;
      end
      check("t6_no_rsp", seen, 0);
      bus.req_valid = 3'b111;
      wait_accept(3'b001, "t6_first");
      bus.req_valid = '0;
      wait_rsp(3'b001, "t6_rsp", lat);
      check("t6_label", bus.rsp_label, RD);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
